// File: rtl/dmem_loader.sv
// rtl/dmem_loader.sv - host byte-stream preload into data memory with readback verify
module dmem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);

  // Counter needs one extra bit so a full-memory length (2^ADDR_W) is representable.
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] wsum;
  logic [DATA_W-1:0] rsum;
  logic              v_first;

  logic              hs;
  logic              last_write;
  logic              verify_read;
  logic              verify_last;
  logic [DATA_W-1:0] rsum_nxt;
  logic [CNT_W-1:0]  len_m1;

  // Handshake and end-of-phase qualifiers shared by the FSM and the datapath.
  always_comb begin
    len_m1      = len_q - CNT_W'(1);
    hs          = in_valid && in_ready;
    last_write  = hs && (cnt == len_m1);
    // The first VERIFY cycle only finishes the final write; reads start after it.
    verify_read = (state == S_VERIFY) && !v_first;
    verify_last = verify_read && (cnt == len_m1);
    rsum_nxt    = rsum + mem_rdata;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (length == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (last_write) begin
          state_nxt = S_VERIFY;
        end
      end
      S_VERIFY: begin
        if (verify_last) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State-decoded outputs; ready is combinational so the host sees it the first LOAD cycle.
  always_comb begin
    in_ready = (state == S_LOAD);
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
  end

  // Memory port, counters, running sums and result flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      cpu_hold  <= 1'b0;
      error     <= 1'b0;
      checksum  <= '0;
      base_q    <= '0;
      len_q     <= '0;
      cnt       <= '0;
      wsum      <= '0;
      rsum      <= '0;
      v_first   <= 1'b0;
    end else begin
      mem_we   <= 1'b0;
      // The CPU is held exactly while the loader owns the memory port.
      cpu_hold <= (state_nxt == S_LOAD) || (state_nxt == S_VERIFY);
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            len_q    <= length;
            cnt      <= '0;
            wsum     <= '0;
            rsum     <= '0;
            checksum <= '0;
            error    <= 1'b0;
            v_first  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (hs) begin
            // Address arithmetic is ADDR_W wide, so a region past the top wraps to 0.
            mem_addr  <= base_q + cnt[ADDR_W-1:0];
            mem_wdata <= in_data;
            mem_we    <= 1'b1;
            wsum      <= wsum + in_data;
            cnt       <= last_write ? '0 : cnt + CNT_W'(1);
          end
        end
        S_VERIFY: begin
          if (v_first) begin
            // Final write lands this cycle; point at the first byte for readback.
            v_first  <= 1'b0;
            mem_addr <= base_q;
          end else begin
            rsum     <= rsum_nxt;
            cnt      <= cnt + CNT_W'(1);
            mem_addr <= base_q + cnt[ADDR_W-1:0] + ADDR_W'(1);
            if (verify_last) begin
              checksum <= wsum;
              error    <= (rsum_nxt != wsum);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_loader.sv
// tb/tb_dmem_loader.sv - directed self-checking bench for dmem_loader
module tb_dmem_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] base_addr;
  logic [8:0] length;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] checksum;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_loader #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error), .checksum(checksum)
  );

  // Memory model: synchronous write, combinational read, optional corruption at 0xFF.
  logic [7:0] mem [0:255];
  logic [7:0] wr_log [0:1023];
  logic       fill_req = 1'b0;
  logic       corrupt  = 1'b0;
  int         wr_cnt   = 0;
  int         done_cnt = 0;
  int         hold_cnt = 0;
  logic [7:0] src [0:255];

  assign mem_rdata = mem[mem_addr] ^ ((corrupt && mem_addr == 8'hFF) ? 8'h01 : 8'h00);

  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h5A;
    end else if (mem_we === 1'b1) begin
      mem[mem_addr]          <= mem_wdata;
      wr_log[wr_cnt % 1024]  <= mem_addr;
      wr_cnt                 <= wr_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (cpu_hold === 1'b1) hold_cnt <= hold_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Runs one operation; dcyc is the cycle (start cycle = 1) in which done is seen, -1 if none.
  task automatic do_load(input logic [7:0] b, input int n, input bit gap, input int abort_at,
                         output int dcyc, output int ready_bad);
    int idx;
    int k;
    bit hs;
    idx = 0;
    dcyc = -1;
    ready_bad = 0;
    base_addr = b;
    length = n[8:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 2;
    while (k < 1200) begin
      if (abort_at > 0 && idx == abort_at) begin
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_mem_we", mem_we, 0);
        check("abort_busy", busy, 0);
        check("abort_hold", cpu_hold, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        return;
      end
      if (done === 1'b1) begin
        dcyc = k;
        break;
      end
      in_valid = (idx < n) && (!gap || (k % 2 == 0));
      in_data = src[idx % 256];
      if (idx < n && in_ready !== 1'b1) ready_bad++;
      hs = in_valid && (in_ready === 1'b1);
      @(posedge clk); #1;
      k++;
      if (hs) idx++;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int dc, rb, w0, d0, h0;
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    base_addr = 8'h00;
    length = 9'd0;
    fill_req = 1'b1;
    // Inputs toggle while reset is held.
    for (int i = 0; i < 2; i++) begin
      start = ~start;
      in_valid = 1'b1;
      in_data = 8'h3C + 8'(i);
      base_addr = 8'h40;
      length = 9'd5;
      @(posedge clk); #1;
    end
    fill_req = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_checksum", checksum, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", busy, 0);
    check("idle_in_ready", in_ready, 0);

    // Back-to-back load of 4 bytes at 0x10.
    src[0] = 8'h01; src[1] = 8'h02; src[2] = 8'h03; src[3] = 8'h04;
    w0 = wr_cnt; d0 = done_cnt; h0 = hold_cnt;
    do_load(8'h10, 4, 1'b0, 0, dc, rb);
    check("t1_done_cycle", dc, 11);
    check("t1_writes", wr_cnt - w0, 4);
    check("t1_addr_first", wr_log[w0], 8'h10);
    check("t1_addr_last", wr_log[w0 + 3], 8'h13);
    check("t1_mem10", mem[8'h10], 8'h01);
    check("t1_mem13", mem[8'h13], 8'h04);
    check("t1_checksum", checksum, 8'h0A);
    check("t1_error", error, 0);
    check("t1_done_pulses", done_cnt - d0, 1);
    check("t1_hold_cycles", hold_cnt - h0, 9);
    check("t1_ready", rb, 0);
    check("t1_busy_after", busy, 0);

    // Gapped load wrapping past 0xFF.
    src[0] = 8'hAA; src[1] = 8'hBB; src[2] = 8'hCC;
    w0 = wr_cnt;
    do_load(8'hFE, 3, 1'b1, 0, dc, rb);
    check("t2_writes", wr_cnt - w0, 3);
    check("t2_addr0", wr_log[w0], 8'hFE);
    check("t2_addr1", wr_log[w0 + 1], 8'hFF);
    check("t2_addr2", wr_log[w0 + 2], 8'h00);
    check("t2_ready_gaps", rb, 0);
    check("t2_checksum", checksum, 8'h31);
    check("t2_error", error, 0);

    // Same load with readback corruption at 0xFF.
    corrupt = 1'b1;
    do_load(8'hFE, 3, 1'b1, 0, dc, rb);
    corrupt = 1'b0;
    check("t3_error", error, 1);
    check("t3_checksum", checksum, 8'h31);

    // Zero-length request.
    w0 = wr_cnt; d0 = done_cnt; h0 = hold_cnt;
    do_load(8'h20, 0, 1'b0, 0, dc, rb);
    check("t4_done_cycle", dc, 2);
    check("t4_writes", wr_cnt - w0, 0);
    check("t4_hold", hold_cnt - h0, 0);
    check("t4_done_pulses", done_cnt - d0, 1);
    check("t4_error", error, 0);
    check("t4_checksum", checksum, 0);

    // Full-memory load aborted by reset after 100 bytes.
    for (int i = 0; i < 256; i++) src[i] = 8'($urandom);
    src[100] = 8'hC3;
    w0 = wr_cnt; d0 = done_cnt;
    do_load(8'h80, 256, 1'b0, 100, dc, rb);
    check("t5_no_done", dc, 32'hFFFF_FFFF);
    check("t5_writes", wr_cnt - w0, 100);
    check("t5_done_pulses", done_cnt - d0, 0);
    check("t5_mem80", mem[8'h80], src[0]);
    check("t5_memE3", mem[8'hE3], src[99]);
    check("t5_memE4", mem[8'hE4], 8'h5A);

    // Normal operation after the abort.
    src[0] = 8'h11; src[1] = 8'h22;
    do_load(8'h00, 2, 1'b0, 0, dc, rb);
    check("t6_done_cycle", dc, 7);
    check("t6_checksum", checksum, 8'h33);
    check("t6_error", error, 0);
    check("t6_mem00", mem[8'h00], 8'h11);
    check("t6_mem01", mem[8'h01], 8'h22);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
